// File: rtl/amba_pkg.sv
// Shared AHB-Lite definitions for the bus masters and slaves on this fabric.
package amba_pkg;

  localparam int AWIDTH = 32;
  localparam int DWIDTH = 32;

  // Largest legal HSIZE for this data bus width.
  localparam int MAX_SIZE = $clog2(DWIDTH / 8);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/amba_master_cmd.sv
// AHB-Lite initiator: runs one local command as a single or INCR burst,
// handling wait states, write-data starvation, 1KB splits and ERROR aborts.
module amba_master_cmd
  import amba_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  output logic [DWIDTH-1:0] rdata,
  output logic              rdata_valid,
  output logic              done,
  output logic              err,
  output logic [AWIDTH-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [DWIDTH-1:0] hwdata,
  input  logic              hready,
  input  logic              hresp,
  input  logic [DWIDTH-1:0] hrdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_ERR} state_t;

  state_t            state_q,  state_d;
  logic [AWIDTH-1:0] haddr_q,  haddr_d;
  logic              hwrite_q, hwrite_d;
  logic [2:0]        hsize_q,  hsize_d;
  logic [2:0]        hburst_q, hburst_d;
  logic [DWIDTH-1:0] hwdata_q, hwdata_d;
  logic [LEN_W-1:0]  len_q,    len_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic              dphase_q, dphase_d;
  logic              nonseq_q, nonseq_d;
  logic              done_q,   done_d;
  logic              err_q,    err_d;

  htrans_t           trans;
  logic [AWIDTH-1:0] next_addr;
  logic [LEN_W-1:0]  issued_inc;
  logic              beat_avail;
  logic              data_err;

  assign next_addr  = haddr_q + (AWIDTH'(1) << hsize_q);
  assign issued_inc = issued_q + LEN_W'(1);
  // A write beat may only be offered to the bus once its data is on hand.
  assign beat_avail = !hwrite_q || wdata_valid;
  assign data_err   = dphase_q && (hresp == HRESP_ERROR) && !hready;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves one unassigned and infers a latch.
    state_d     = state_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    hburst_d    = hburst_q;
    hwdata_d    = hwdata_q;
    len_d       = len_q;
    issued_d    = issued_q;
    dphase_d    = dphase_q;
    nonseq_d    = nonseq_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cmd_ready   = 1'b0;
    wdata_ready = 1'b0;
    rdata_valid = 1'b0;
    trans       = IDLE;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else if (cmd_size > 3'(MAX_SIZE)) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d  = ST_ADDR;
            haddr_d  = cmd_addr;
            hwrite_d = cmd_write;
            hsize_d  = cmd_size;
            hburst_d = (cmd_len == LEN_W'(1)) ? HBURST_SINGLE : HBURST_INCR;
            len_d    = cmd_len;
            issued_d = '0;
            dphase_d = 1'b0;
            nonseq_d = 1'b1;
          end
        end
      end

      ST_ADDR: begin
        rdata_valid = dphase_q && !hwrite_q && hready && (hresp == HRESP_OKAY);
        if (data_err) begin
          // Cancel the pending address phase in the first ERROR cycle.
          state_d  = ST_ERR;
          dphase_d = 1'b0;
        end else begin
          if (beat_avail) trans = nonseq_q ? NONSEQ : SEQ;
          else            trans = (issued_q == '0) ? IDLE : BUSY;
          if (hready) begin
            dphase_d = beat_avail;
            if (beat_avail) begin
              wdata_ready = hwrite_q;
              if (hwrite_q) hwdata_d = wdata;
              issued_d = issued_inc;
              if (issued_inc == len_q) begin
                state_d = ST_DATA;
              end else begin
                haddr_d  = next_addr;
                nonseq_d = next_addr[10] != haddr_q[10];
              end
            end
          end
        end
      end

      ST_DATA: begin
        rdata_valid = !hwrite_q && hready && (hresp == HRESP_OKAY);
        if (data_err) begin
          state_d  = ST_ERR;
          dphase_d = 1'b0;
        end else if (hready) begin
          state_d  = ST_IDLE;
          dphase_d = 1'b0;
          done_d   = 1'b1;
          err_d    = (hresp == HRESP_ERROR);
        end
      end

      ST_ERR: begin
        if (hready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hsize_q  <= '0;
      hburst_q <= '0;
      hwdata_q <= '0;
      len_q    <= '0;
      issued_q <= '0;
      dphase_q <= 1'b0;
      nonseq_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      hsize_q  <= hsize_d;
      hburst_q <= hburst_d;
      hwdata_q <= hwdata_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      dphase_q <= dphase_d;
      nonseq_q <= nonseq_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign htrans = trans;
  assign haddr  = haddr_q;
  assign hwrite = hwrite_q;
  assign hsize  = hsize_q;
  assign hburst = hburst_q;
  assign hwdata = hwdata_q;
  assign rdata  = hrdata;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_amba_master_cmd.sv
// Bench for amba_master_cmd: a cycle-level AHB slave plus a per-command
// model of the expected transfer sequence, directed cases then random ones.
module tb_amba_master_cmd;
  import amba_pkg::*;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [AWIDTH-1:0] cmd_addr;
  logic [2:0]        cmd_size;
  logic [LEN_W-1:0]  cmd_len;
  logic [DWIDTH-1:0] wdata;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DWIDTH-1:0] rdata;
  logic              rdata_valid;
  logic              done;
  logic              err;
  logic [AWIDTH-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [DWIDTH-1:0] hwdata;
  logic              hready;
  logic              hresp;
  logic [DWIDTH-1:0] hrdata;

  int n_tests = 0;
  int n_fail  = 0;

  // Slave memory contents; doubles as the expected read data.
  logic [31:0] mem [logic [31:0]];

  amba_master_cmd #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_len(cmd_len),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .err(err),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hwdata(hwdata), .hready(hready), .hresp(hresp),
    .hrdata(hrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // One command end to end. err_beat<0: no error; wait0<0: random waits on beat 0;
  // gap_after0 forces wdata_valid low for that many cycles after beat 0 is issued.
  task automatic run_cmd(input bit wr, input logic [31:0] addr, input int size, input int len,
                         input logic [31:0] wbase, input int err_beat, input int wait0,
                         input int wait_max, input int gap_after0, input int gap_pct);
    logic [31:0] step_b, a_cur, a_prev;
    bit legal, exp_err, dp_valid, err_ph, done_due, done_due_nx, done_seen, wv, rv_exp;
    int exp_issued, exp_rv, issued, rv_cnt, dp_beat, dp_wait, hold;
    htrans_t exp_t;

    step_b   = 32'd1 << size;
    legal    = (len > 0) && (size <= MAX_SIZE);
    exp_err  = (len > 0 && size > MAX_SIZE) || (legal && err_beat >= 0 && err_beat < len);
    exp_issued = !legal ? 0 : ((err_beat >= 0 && err_beat < len) ? err_beat + 1 : len);
    exp_rv   = (!legal || wr) ? 0 : ((err_beat >= 0 && err_beat < len) ? err_beat : len);
    issued = 0; rv_cnt = 0; dp_beat = 0; dp_wait = 0; hold = 0;
    dp_valid = 0; err_ph = 0; done_seen = 0; wv = 0;

    cmd_write = wr; cmd_addr = addr; cmd_size = 3'(size); cmd_len = LEN_W'(len);
    cmd_valid = 1'b1; hready = 1'b1; hresp = 1'b0; wdata_valid = 1'b0;
    @(negedge clk);
    check("cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    done_due = !legal;

    for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
      hready = 1'b1; hresp = 1'b0; hrdata = $urandom;
      if (dp_valid) begin
        if (dp_wait > 0) hready = 1'b0;
        else if (dp_beat == err_beat) begin
          hresp  = 1'b1;
          hready = err_ph;
        end else if (!wr) hrdata = mem_rd(addr + dp_beat * step_b);
      end
      if (wr && legal && issued < len && !err_ph) begin
        if (hold > 0) hold--;
        else if (!wv) wv = ($urandom_range(99) >= gap_pct);
      end
      wdata_valid = wv;
      wdata = wbase + issued;

      @(negedge clk);
      a_cur  = addr + issued * step_b;
      a_prev = a_cur - step_b;
      if (!legal || issued >= len || err_ph || (dp_valid && hresp)) exp_t = IDLE;
      else if (wr && !wv) exp_t = (issued == 0) ? IDLE : BUSY;
      else if (issued == 0 || a_cur[10] != a_prev[10]) exp_t = NONSEQ;
      else exp_t = SEQ;

      check("htrans", 32'(htrans), 32'(exp_t));
      if (exp_t != IDLE) check("haddr", haddr, a_cur);
      if (exp_t inside {NONSEQ, SEQ} && hready) begin
        check("hwrite", 32'(hwrite), 32'(wr));
        check("hsize", 32'(hsize), 32'(size));
        check("hburst", 32'(hburst), (len == 1) ? 32'(HBURST_SINGLE) : 32'(HBURST_INCR));
      end
      check("wdata_ready", 32'(wdata_ready), 32'(exp_t inside {NONSEQ, SEQ} && hready && wr));
      rv_exp = dp_valid && !wr && hready && !hresp;
      check("rdata_valid", 32'(rdata_valid), 32'(rv_exp));
      if (rv_exp) begin
        check("rdata", rdata, mem_rd(addr + dp_beat * step_b));
        rv_cnt++;
      end
      if (dp_valid && wr && hready && !hresp) begin
        check("hwdata", hwdata, wbase + dp_beat);
        mem[addr + dp_beat * step_b] = wbase + dp_beat;
      end
      check("done", 32'(done), 32'(done_due));
      if (done) check("err", 32'(err), 32'(exp_err));
      done_seen = done_due || done;

      done_due_nx = 1'b0;
      if (dp_valid) begin
        if (hready) begin
          dp_valid = 1'b0;
          if (hresp || dp_beat == len - 1) done_due_nx = 1'b1;
        end else if (hresp) err_ph = 1'b1;
        else dp_wait--;
      end
      if (exp_t inside {NONSEQ, SEQ} && hready) begin
        dp_valid = 1'b1;
        dp_beat  = issued;
        dp_wait  = (issued == 0 && wait0 >= 0) ? wait0 : int'($urandom_range(wait_max));
        issued++;
        wv = 1'b0;
        if (issued == 1) hold = gap_after0;
      end
      done_due = done_due_nx;
      @(posedge clk); #1;
    end

    check("done_seen", 32'(done_seen), 32'd1);
    check("beats_issued", 32'(issued), 32'(exp_issued));
    if (!wr) check("rdata_valid_count", 32'(rv_cnt), 32'(exp_rv));
  endtask

  task automatic reset_mid_burst();
    cmd_write = 1'b0; cmd_addr = 32'h200; cmd_size = 3'd2; cmd_len = LEN_W'(8);
    cmd_valid = 1'b1; hready = 1'b1; hresp = 1'b0; wdata_valid = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_pre_htrans", 32'(htrans), 32'(SEQ));
    rst = 1'b1;
    #1;
    check("rst_async_htrans", 32'(htrans), 32'(IDLE));
    check("rst_async_haddr", haddr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_post_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_post_done", 32'(done), 32'd0);
      check("rst_post_htrans", 32'(htrans), 32'(IDLE));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int sz, ln, eb;
    logic [31:0] step_b, a;

    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
    cmd_len = '0; wdata = '0; wdata_valid = 1'b0; hready = 1'b1; hresp = 1'b0; hrdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_htrans", 32'(htrans), 32'(IDLE));
    check("reset_haddr", haddr, 32'h0);
    check("reset_hwdata", hwdata, 32'h0);
    check("reset_hsize", 32'(hsize), 32'd0);
    check("reset_hburst", 32'(hburst), 32'd0);
    check("reset_hwrite", 32'(hwrite), 32'd0);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_cmd(1'b1, 32'h10,  2, 4, 32'hA0, -1, 0, 0, 0, 0);
    run_cmd(1'b0, 32'h20,  2, 2, 32'h0,  -1, 2, 0, 0, 0);
    run_cmd(1'b1, 32'h40,  2, 3, 32'hB0, -1, 0, 0, 2, 0);
    run_cmd(1'b1, 32'h3F8, 2, 4, 32'hC0, -1, 0, 0, 0, 0);
    run_cmd(1'b0, 32'h10,  2, 4, 32'h0,   1, 0, 0, 0, 0);
    run_cmd(1'b0, 32'h100, 2, 0, 32'h0,  -1, 0, 0, 0, 0);
    run_cmd(1'b1, 32'h100, 3, 2, 32'hD0, -1, 0, 0, 0, 0);
    run_cmd(1'b0, 32'h3F8, 2, 4, 32'h0,  -1, 0, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      sz = ($urandom_range(9) == 0) ? 3 : int'($urandom_range(2));
      ln = ($urandom_range(8) == 0) ? 0 : int'($urandom_range(16, 1));
      step_b = 32'd1 << sz;
      if ($urandom_range(1) == 1) a = 32'h400 * $urandom_range(8, 1) - step_b * $urandom_range(8);
      else a = $urandom & 32'hFFFF;
      a = a & ~(step_b - 32'd1);
      eb = ($urandom_range(4) == 0 && ln > 0) ? int'($urandom_range(ln - 1)) : -1;
      run_cmd(1'($urandom_range(1)), a, sz, ln, $urandom, eb, -1, 2, 0, 30);
    end

    reset_mid_burst();
    run_cmd(1'b0, 32'h10, 2, 4, 32'h0, -1, -1, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
